// File: rtl/chip8_pkg.sv
// Shared constants and types for the CHIP-8 keypad input stage.
package chip8_pkg;

  localparam int NUM_KEYS               = 16;
  localparam int DEFAULT_TICK_DIV       = 2048;
  localparam int DEFAULT_DEBOUNCE_TICKS = 4;
  localparam int DEFAULT_REPEAT_DELAY   = 32;
  localparam int DEFAULT_REPEAT_RATE    = 8;

  typedef logic [3:0] key_t;

  // Auto-repeat tracker state: waiting for the first repeat or for later ones.
  typedef enum logic [1:0] {
    REP_IDLE  = 2'd0,
    REP_DELAY = 2'd1,
    REP_RATE  = 2'd2
  } rep_state_t;

  // Index of the lowest set bit. Returns 0 for an empty mask.
  function automatic key_t lowest_key(input logic [NUM_KEYS-1:0] mask);
    key_t k;
    k = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (mask[i]) k = key_t'(i);
    end
    return k;
  endfunction

endpackage

// File: rtl/keypad_debounce_bit.sv
// One keypad key: 2-flop synchroniser, tick-driven debounce counter and
// the committed (debounced) level. rise pulses in the cycle a 0->1 commit
// is being made so the parent can latch it in the same edge.
module keypad_debounce_bit
  import chip8_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic level,
  output logic rise
);

  localparam logic [2:0] CNT_LAST = 3'(DEBOUNCE_TICKS - 1);

  logic       meta_q, meta_d;
  logic       sync_q, sync_d;
  logic       level_q, level_d;
  logic [2:0] cnt_q, cnt_d;

  // Synchronise the raw switch and count consecutive differing samples.
  always_comb begin
    meta_d  = raw;
    sync_d  = meta_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    rise    = 1'b0;
    if (tick) begin
      if (sync_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        cnt_d   = '0;
        rise    = ~level_q;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  // State registers; reset discards any debounce progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/chip8_keypad_scanner.sv
// CHIP-8 keypad scanner: synchronises and debounces the two switch banks,
// drives the debounced keypad_matrix and emits one key_event per new press
// (lowest key first when several are pending).
// Optional auto-repeat of the last emitted key: define KEYPAD_REPEAT_EN.
module chip8_keypad_scanner
  import chip8_pkg::*;
#(
  parameter int TICK_DIV       = DEFAULT_TICK_DIV,
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter int REPEAT_DELAY   = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_RATE    = DEFAULT_REPEAT_RATE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  switches_p1,
  input  logic [7:0]  switches_p2,
  output logic [15:0] keypad_matrix,
  output logic        key_event,
  output logic [3:0]  key_code
);

  localparam int               PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_chk_div
    $error("TICK_DIV must be at least 2");
  end
  if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 7) begin : g_chk_deb
    $error("DEBOUNCE_TICKS must be in 1..7");
  end
  if (REPEAT_DELAY < 1 || REPEAT_DELAY > 256 || REPEAT_RATE < 1 || REPEAT_RATE > 256) begin : g_chk_rep
    $error("REPEAT_DELAY and REPEAT_RATE must be in 1..256");
  end

  logic [NUM_KEYS-1:0] raw;
  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] rep_set;
  logic [NUM_KEYS-1:0] clear_mask;
  logic [NUM_KEYS-1:0] pending_q, pending_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                tick;
  logic                key_event_q, key_event_d;
  key_t                key_code_q, key_code_d;

  assign raw = {switches_p2, switches_p1};

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    keypad_debounce_bit #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_bit (
      .clk  (clk),
      .reset(reset),
      .raw  (raw[i]),
      .tick (tick),
      .level(level[i]),
      .rise (rise[i])
    );
  end

  // Free-running prescaler producing a one-cycle debounce sample tick.
  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
  end

  // Emit the lowest pending press; a fresh commit in the same cycle wins.
  always_comb begin
    key_event_d = 1'b0;
    key_code_d  = key_code_q;
    clear_mask  = '0;
    if (pending_q != '0) begin
      key_event_d             = 1'b1;
      key_code_d              = lowest_key(pending_q);
      clear_mask[key_code_d]  = 1'b1;
    end
    pending_d = (pending_q & ~clear_mask) | rise | rep_set;
  end

  // Prescaler, pending mask and registered event outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q       <= '0;
      pending_q   <= '0;
      key_event_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      pre_q       <= pre_d;
      pending_q   <= pending_d;
      key_event_q <= key_event_d;
      key_code_q  <= key_code_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  rep_state_t rep_state_q, rep_state_d;
  key_t       rep_key_q, rep_key_d;
  logic [7:0] rep_cnt_q, rep_cnt_d;
  logic [7:0] rep_target;

  // Track the last emitted key and re-arm its pending bit while it is held.
  always_comb begin
    rep_state_d = rep_state_q;
    rep_key_d   = rep_key_q;
    rep_cnt_d   = rep_cnt_q;
    rep_set     = '0;
    rep_target  = (rep_state_q == REP_DELAY) ? 8'(REPEAT_DELAY - 1) : 8'(REPEAT_RATE - 1);
    if (key_event_d) begin
      if (rep_state_q == REP_IDLE || key_code_d != rep_key_q) begin
        rep_state_d = REP_DELAY;
      end
      rep_key_d = key_code_d;
      rep_cnt_d = '0;
    end else if (tick && rep_state_q != REP_IDLE) begin
      if (!level[rep_key_q]) begin
        rep_state_d = REP_IDLE;
      end else if (rep_cnt_q == rep_target) begin
        rep_set[rep_key_q] = 1'b1;
        rep_cnt_d          = '0;
        rep_state_d        = REP_RATE;
      end else begin
        rep_cnt_d = rep_cnt_q + 8'd1;
      end
    end
  end

  // Repeat tracker registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_state_q <= REP_IDLE;
      rep_key_q   <= '0;
      rep_cnt_q   <= '0;
    end else begin
      rep_state_q <= rep_state_d;
      rep_key_q   <= rep_key_d;
      rep_cnt_q   <= rep_cnt_d;
    end
  end
`else
  assign rep_set = '0;
`endif

  assign keypad_matrix = level;
  assign key_event     = key_event_q;
  assign key_code      = key_code_q;

endmodule

// File: tb/tb_chip8_keypad_scanner.sv
// Self-checking bench for chip8_keypad_scanner (fast tick settings).
`timescale 1ns/1ps
module tb_chip8_keypad_scanner;
  import chip8_pkg::*;

  localparam int TB_TICK_DIV  = 4;
  localparam int TB_DEB       = 4;
  localparam int TB_REP_DELAY = 3;
  localparam int TB_REP_RATE  = 2;
  localparam int MAX_LAT      = 2 + TB_DEB * TB_TICK_DIV;
  localparam int MIN_LAT      = 3 + (TB_DEB - 1) * TB_TICK_DIV;

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  switches_p1 = '0;
  logic [7:0]  switches_p2 = '0;
  logic [15:0] keypad_matrix;
  logic        key_event;
  logic [3:0]  key_code;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  obs_t obs_q[$];
  obs_t mon_ev;
  int   obs_rd = 0;
  int   exp_q[$];

  chip8_keypad_scanner #(
    .TICK_DIV      (TB_TICK_DIV),
    .DEBOUNCE_TICKS(TB_DEB),
    .REPEAT_DELAY  (TB_REP_DELAY),
    .REPEAT_RATE   (TB_REP_RATE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .switches_p1  (switches_p1),
    .switches_p2  (switches_p2),
    .keypad_matrix(keypad_matrix),
    .key_event    (key_event),
    .key_code     (key_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every event the DUT produces, stamped with the cycle it appeared.
  always @(negedge clk) begin
    if (!reset && key_event === 1'b1) begin
      mon_ev.code = key_code;
      mon_ev.cyc  = cyc;
      obs_q.push_back(mon_ev);
    end
  end

  // Auto-repeat traffic is covered by test_repeat; elsewhere it is dropped.
  task automatic discard_repeats();
`ifdef KEYPAD_REPEAT_EN
    obs_rd = obs_q.size();
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    switches_p1 = '0;
    switches_p2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (keypad_matrix !== 16'h0000) begin
      $display("[TB] FAIL reset_matrix: got %h expected 0000", keypad_matrix); errors++;
    end
    checks++;
    if (key_event !== 1'b0) begin
      $display("[TB] FAIL reset_event: got %b expected 0", key_event); errors++;
    end
    checks++;
    if (key_code !== 4'd0) begin
      $display("[TB] FAIL reset_code: got %0d expected 0", key_code); errors++;
    end
    @(posedge clk); #1 reset = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    checks++;
    if (keypad_matrix !== 16'h0000) begin
      $display("[TB] FAIL idle_matrix: got %h expected 0000", keypad_matrix); errors++;
    end
    checks++;
    if (obs_q.size() != 0) begin
      $display("[TB] FAIL idle_events: got %0d events expected 0", obs_q.size()); errors++;
    end
    obs_rd = obs_q.size();
  endtask

  task automatic test_single_press();
    int   start, lat, commit, exp_code;
    bit   seen;
    obs_t ev;
    @(posedge clk); #1;
    switches_p1[5] = 1'b1;
    exp_q.push_back(5);
    start = cyc;
    seen  = 1'b0;
    for (int n = 0; n < MAX_LAT + 4; n++) begin
      @(negedge clk);
      if (keypad_matrix !== 16'h0000) begin seen = 1'b1; break; end
    end
    lat    = cyc - start;
    commit = cyc;
    checks++;
    if (!seen || lat < MIN_LAT || lat > MAX_LAT) begin
      $display("[TB] FAIL press5_latency: got %0d cycles (seen=%0b) expected %0d..%0d", lat, seen, MIN_LAT, MAX_LAT); errors++;
    end
    checks++;
    if (keypad_matrix !== 16'h0020) begin
      $display("[TB] FAIL press5_matrix: got %h expected 0020", keypad_matrix); errors++;
    end
    repeat (4) @(negedge clk);
    exp_code = exp_q.pop_front();
    checks++;
    if (obs_rd >= obs_q.size()) begin
      $display("[TB] FAIL press5_event: got no event expected key_code %0d", exp_code); errors++;
    end else begin
      ev = obs_q[obs_rd];
      obs_rd++;
      if (ev.code !== 4'(exp_code)) begin
        $display("[TB] FAIL press5_code: got %0d expected %0d", ev.code, exp_code); errors++;
      end
      checks++;
      if (ev.cyc != commit + 1) begin
        $display("[TB] FAIL press5_event_cycle: got %0d expected %0d", ev.cyc, commit + 1); errors++;
      end
    end
`ifndef KEYPAD_REPEAT_EN
    repeat (60) @(negedge clk);
    checks++;
    if (obs_q.size() != obs_rd) begin
      $display("[TB] FAIL press5_no_repeat: got %0d extra events expected 0", obs_q.size() - obs_rd); errors++;
    end
`endif
    @(posedge clk); #1;
    switches_p1[5] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < MAX_LAT + 4; n++) begin
      @(negedge clk);
      if (keypad_matrix === 16'h0000) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      $display("[TB] FAIL release5_matrix: got %h expected 0000", keypad_matrix); errors++;
    end
    repeat (4) @(negedge clk);
    discard_repeats();
    checks++;
    if (obs_q.size() != obs_rd) begin
      $display("[TB] FAIL release5_events: got %0d events expected 0", obs_q.size() - obs_rd); errors++;
    end
    obs_rd = obs_q.size();
  endtask

  task automatic test_glitch();
    @(posedge clk); #1;
    switches_p2[2] = 1'b1;
    repeat (10) @(posedge clk);
    #1 switches_p2[2] = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (keypad_matrix !== 16'h0000) begin
      $display("[TB] FAIL glitch_matrix: got %h expected 0000", keypad_matrix); errors++;
    end
    checks++;
    if (obs_q.size() != obs_rd) begin
      $display("[TB] FAIL glitch_events: got %0d events expected 0", obs_q.size() - obs_rd); errors++;
    end
    obs_rd = obs_q.size();
  endtask

  task automatic test_back_to_back();
    int   commit, exp_code;
    bit   seen;
    obs_t ev;
    @(posedge clk); #1;
    switches_p1[7] = 1'b1;
    switches_p2[0] = 1'b1;
    switches_p1[1] = 1'b1;
    exp_q.push_back(1);
    exp_q.push_back(7);
    exp_q.push_back(8);
    seen = 1'b0;
    for (int n = 0; n < MAX_LAT + 4; n++) begin
      @(negedge clk);
      if (keypad_matrix !== 16'h0000) begin seen = 1'b1; break; end
    end
    commit = cyc;
    checks++;
    if (!seen || keypad_matrix !== 16'h0182) begin
      $display("[TB] FAIL multi_matrix: got %h expected 0182", keypad_matrix); errors++;
    end
    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      exp_code = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_q.size()) begin
        $display("[TB] FAIL multi_event%0d: got no event expected key_code %0d", k, exp_code); errors++;
      end else begin
        ev = obs_q[obs_rd];
        obs_rd++;
        if (ev.code !== 4'(exp_code)) begin
          $display("[TB] FAIL multi_code%0d: got %0d expected %0d", k, ev.code, exp_code); errors++;
        end
        checks++;
        if (ev.cyc != commit + 1 + k) begin
          $display("[TB] FAIL multi_cycle%0d: got %0d expected %0d", k, ev.cyc, commit + 1 + k); errors++;
        end
      end
    end
    @(posedge clk); #1;
    switches_p1 = '0;
    switches_p2 = '0;
    seen = 1'b0;
    for (int n = 0; n < MAX_LAT + 4; n++) begin
      @(negedge clk);
      if (keypad_matrix === 16'h0000) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      $display("[TB] FAIL multi_release: got %h expected 0000", keypad_matrix); errors++;
    end
    repeat (4) @(negedge clk);
    discard_repeats();
    checks++;
    if (obs_q.size() != obs_rd) begin
      $display("[TB] FAIL multi_extra: got %0d extra events expected 0", obs_q.size() - obs_rd); errors++;
    end
    obs_rd = obs_q.size();
  endtask

  task automatic test_reset_mid_debounce();
    int   exp_code;
    bit   seen;
    obs_t ev;
    @(posedge clk); #1;
    switches_p1[3] = 1'b1;
    exp_q.push_back(3);
    seen = 1'b0;
    for (int n = 0; n < MAX_LAT + 4; n++) begin
      @(negedge clk);
      if (keypad_matrix !== 16'h0000) begin seen = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
    exp_code = exp_q.pop_front();
    checks++;
    if (!seen || obs_rd >= obs_q.size()) begin
      $display("[TB] FAIL key3_event: got no event expected key_code %0d", exp_code); errors++;
    end else begin
      ev = obs_q[obs_rd];
      obs_rd++;
      if (ev.code !== 4'(exp_code)) begin
        $display("[TB] FAIL key3_code: got %0d expected %0d", ev.code, exp_code); errors++;
      end
    end
    @(posedge clk); #1;
    switches_p1[3] = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (keypad_matrix !== 16'h0008) begin
      $display("[TB] FAIL key3_held_mid_release: got %h expected 0008", keypad_matrix); errors++;
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (keypad_matrix !== 16'h0000) begin
      $display("[TB] FAIL midreset_matrix: got %h expected 0000", keypad_matrix); errors++;
    end
    checks++;
    if (key_event !== 1'b0) begin
      $display("[TB] FAIL midreset_event: got %b expected 0", key_event); errors++;
    end
    checks++;
    if (key_code !== 4'd0) begin
      $display("[TB] FAIL midreset_code: got %0d expected 0", key_code); errors++;
    end
    discard_repeats();
    repeat (40) @(negedge clk);
    checks++;
    if (keypad_matrix !== 16'h0000 || obs_q.size() != obs_rd) begin
      $display("[TB] FAIL midreset_quiet: got matrix %h and %0d events expected 0000 and 0", keypad_matrix, obs_q.size() - obs_rd); errors++;
    end
    obs_rd = obs_q.size();
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    int   start_rd, commit, rel, e, idx;
    int   exp_cyc[$];
    bit   seen;
    obs_t ev;
    start_rd = obs_rd;
    @(posedge clk); #1;
    switches_p2[2] = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < MAX_LAT + 4; n++) begin
      @(negedge clk);
      if (keypad_matrix !== 16'h0000) begin seen = 1'b1; break; end
    end
    commit = cyc;
    checks++;
    if (!seen || keypad_matrix !== 16'h0400) begin
      $display("[TB] FAIL rep_matrix: got %h expected 0400", keypad_matrix); errors++;
    end
    repeat (30) @(negedge clk);
    @(posedge clk); #1;
    switches_p2[2] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < MAX_LAT + 4; n++) begin
      @(negedge clk);
      if (keypad_matrix === 16'h0000) begin seen = 1'b1; break; end
    end
    rel = cyc;
    checks++;
    if (!seen) begin
      $display("[TB] FAIL rep_release: got %h expected 0000", keypad_matrix); errors++;
    end
    repeat (30) @(negedge clk);
    e = commit + 1;
    exp_cyc.push_back(e);
    exp_q.push_back(10);
    e = e + TB_REP_DELAY * TB_TICK_DIV;
    while (e - 1 <= rel) begin
      exp_cyc.push_back(e);
      exp_q.push_back(10);
      e = e + TB_REP_RATE * TB_TICK_DIV;
    end
    checks++;
    if (obs_q.size() - start_rd != exp_q.size()) begin
      $display("[TB] FAIL rep_count: got %0d events expected %0d", obs_q.size() - start_rd, exp_q.size()); errors++;
    end
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_q.size()) begin
        ev = obs_q[obs_rd];
        obs_rd++;
        checks++;
        if (ev.code !== 4'(e) || ev.cyc != exp_cyc[idx]) begin
          $display("[TB] FAIL rep_event%0d: got code %0d at %0d expected code %0d at %0d", idx, ev.code, ev.cyc, e, exp_cyc[idx]); errors++;
        end
      end
      idx++;
    end
    obs_rd = obs_q.size();
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_back_to_back();
    test_reset_mid_debounce();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      $display("[TB] FAIL scoreboard_left: got %0d unmatched expectations expected 0", exp_q.size()); errors++;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
